// File: rtl/spi_program_loader_if.sv
// rtl/spi_program_loader_if.sv - host byte stream into the SPI program loader
interface spi_program_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_last;

  modport master (output in_valid, in_data, in_sel, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_sel, in_last, output in_ready);
endinterface

// File: rtl/spi_program_loader.sv
// rtl/spi_program_loader.sv - serialises host bytes MSB first onto an instruction or data
// SPI memory, inserts an idle gap between bursts, then hands control to the processor.
module spi_program_loader #(
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_program_loader_if.slave        host,
  input  logic                       run_i,
  output logic                       csi,
  output logic                       csd,
  output logic                       mosi,
  output logic                       proc_en,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, RUN} state_t;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] gap_cnt, gap_cnt_n;
  logic [7:0] byte_q, byte_n;
  logic       sel_q, sel_n;
  logic       last_q, last_n;
  logic       csi_n, csd_n, mosi_n, proc_en_n, busy_n;
  logic       ready_c;
  logic       take;

  // A new byte may only chain onto the current burst when it targets the same memory.
  always_comb begin
    ready_c = 1'b0;
    case (state)
      IDLE:    ready_c = !run_i;
      SHIFT:   ready_c = (bit_cnt == 3'd0) && !last_q && (host.in_sel == sel_q);
      default: ready_c = 1'b0;
    endcase
  end

  assign host.in_ready = ready_c && !rst;
  assign take          = host.in_valid && host.in_ready;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    byte_n    = byte_q;
    sel_n     = sel_q;
    last_n    = last_q;
    csi_n     = 1'b1;
    csd_n     = 1'b1;
    mosi_n    = 1'b0;
    proc_en_n = 1'b0;

    case (state)
      IDLE: begin
        if (run_i) begin
          state_n   = RUN;
          proc_en_n = 1'b1;
        end else if (take) begin
          state_n   = SHIFT;
          bit_cnt_n = 3'd7;
          byte_n    = host.in_data;
          sel_n     = host.in_sel;
          last_n    = host.in_last;
          mosi_n    = host.in_data[7];
          csi_n     = host.in_sel;
          csd_n     = !host.in_sel;
        end
      end
      SHIFT: begin
        if (bit_cnt != 3'd0) begin
          bit_cnt_n = bit_cnt - 3'd1;
          mosi_n    = byte_q[bit_cnt - 3'd1];
          csi_n     = sel_q;
          csd_n     = !sel_q;
        end else if (take) begin
          bit_cnt_n = 3'd7;
          byte_n    = host.in_data;
          sel_n     = host.in_sel;
          last_n    = host.in_last;
          mosi_n    = host.in_data[7];
          csi_n     = host.in_sel;
          csd_n     = !host.in_sel;
        end else if (last_q || (host.in_valid && (host.in_sel != sel_q))) begin
          state_n   = GAP;
          gap_cnt_n = 4'(GAP_CYCLES - 1);
        end else begin
          state_n   = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_n = IDLE;
        else                 gap_cnt_n = gap_cnt - 4'd1;
      end
      RUN: begin
        if (run_i) proc_en_n = 1'b1;
        else       state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SHIFT) || (state_n == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      gap_cnt <= 4'd0;
      byte_q  <= 8'd0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      csi     <= 1'b1;
      csd     <= 1'b1;
      mosi    <= 1'b0;
      proc_en <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      byte_q  <= byte_n;
      sel_q   <= sel_n;
      last_q  <= last_n;
      csi     <= csi_n;
      csd     <= csd_n;
      mosi    <= mosi_n;
      proc_en <= proc_en_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_program_loader.sv
// tb/tb_spi_program_loader.sv - bench for spi_program_loader: cycle vector table,
// a framing sequence, and randomized bursts scored byte by byte.
module tb_spi_program_loader;

  logic clk;
  logic rst;
  logic run_i;
  logic csi, csd, mosi, proc_en, busy;

  spi_program_loader_if bus();

  spi_program_loader #(.GAP_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (bus),
    .run_i   (run_i),
    .csi     (csi),
    .csd     (csd),
    .mosi    (mosi),
    .proc_en (proc_en),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One row = inputs for a cycle, in_ready expected before the edge,
  // {csi,csd,mosi,busy,proc_en} expected after the edge.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       run;
    logic       rs;
    logic       erdy;
    logic [4:0] eo;
  } vec_t;

  vec_t tbl[$];

  localparam logic [4:0] O_IDLE = 5'b11000;
  localparam logic [4:0] O_GAP  = 5'b11010;
  localparam logic [4:0] O_RUN  = 5'b11001;

  task automatic add(input logic v, input logic [7:0] d, input logic s, input logic l,
                     input logic run, input logic rs, input logic erdy, input logic [4:0] eo);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.l = l; r.run = run; r.rs = rs; r.erdy = erdy; r.eo = eo;
    tbl.push_back(r);
  endtask

  // Eight rows: the accepting cycle, then seven cycles each showing the next lower bit.
  task automatic add_byte(input logic [7:0] d, input logic s, input logic l,
                          input logic erdy0, input int run_from);
    for (int k = 0; k < 8; k++) begin
      add(k == 0, d, s, l, k >= run_from, 1'b0, (k == 0) ? erdy0 : 1'b0,
          {s, !s, d[7-k], 1'b1, 1'b0});
    end
  endtask

  // Final bit of a burst ending with last = 1, then the two gap cycles.
  task automatic add_exit(input logic s, input logic rg);
    add(1'b0, 8'h00, s, 1'b0, 1'b0, 1'b0, 1'b0, O_GAP);
    add(1'b0, 8'h00, s, 1'b0, rg,   1'b0, 1'b0, O_GAP);
    add(1'b0, 8'h00, s, 1'b0, rg,   1'b0, 1'b0, O_IDLE);
  endtask

  // Byte-level scoreboard: {sel, byte} in acceptance order.
  logic [8:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] sh;
  logic       mon_sel;
  int         nbits = 0;

  task automatic send(input logic [7:0] d, input logic s, input logic l);
    logic rdy;
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sel = s; bus.in_last = l;
    for (int i = 0; i < 200; i++) begin
      #1 rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("send_accept", got, 1'b1);
    if (got) exp_q.push_back({s, d});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && (!csi || !csd)) begin
      chk("cs_exclusive", {csi, csd}, (!csi) ? 2'b01 : 2'b10);
      chk("cs_vs_proc_en", proc_en, 1'b0);
      if (nbits == 0) mon_sel = csi;
      sh = {sh[6:0], mosi};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        if (exp_q.size() == 0) chk("unexpected_byte", {mon_sel, sh}, 9'h1ff + 32'h1);
        else chk("byte", {mon_sel, sh}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int g;
    logic s;
    logic [7:0] d;

    rst = 1'b1; run_i = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_sel = 1'b0; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);

    // reset, with a valid byte waiting that must not be taken
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE);
    // single byte 0xA5 to instruction memory, then gap
    add_byte(8'hA5, 1'b0, 1'b1, 1'b1, 8);
    add_exit(1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE);
    // back-to-back burst 0x3C, 0xFF to data memory
    add_byte(8'h3C, 1'b1, 1'b0, 1'b1, 8);
    add_byte(8'hFF, 1'b1, 1'b1, 1'b1, 8);
    add_exit(1'b1, 1'b0);
    // 0x81 to instruction, then 0x81 to data offered at the last bit forces a gap
    add_byte(8'h81, 1'b0, 1'b0, 1'b1, 8);
    add(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_GAP);
    add(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_GAP);
    add(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
    add_byte(8'h81, 1'b1, 1'b1, 1'b1, 8);
    add_exit(1'b1, 1'b0);
    // run_i raised mid-byte: byte completes, then RUN, then release
    add_byte(8'h5A, 1'b0, 1'b0, 1'b1, 5);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE);
    // reset pulse at bit 5 of 0xF0, then 0x0F clean
    add(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01110);
    add(1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01110);
    add(1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01110);
    add(1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE);
    add_byte(8'h0F, 1'b0, 1'b1, 1'b1, 8);
    add_exit(1'b0, 1'b0);
    // run_i beats in_valid in IDLE; run_i during GAP waits for IDLE
    add(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN);
    add(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
    add_byte(8'h99, 1'b0, 1'b1, 1'b1, 8);
    add_exit(1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.in_valid = tbl[i].v; bus.in_data = tbl[i].d;
      bus.in_sel = tbl[i].s; bus.in_last = tbl[i].l;
      run_i = tbl[i].run; rst = tbl[i].rs;
      #1 chk($sformatf("row%0d_ready", i), bus.in_ready, tbl[i].erdy);
      @(posedge clk);
      #1 chk($sformatf("row%0d_out", i), {csi, csd, mosi, busy, proc_en}, tbl[i].eo);
    end

    @(negedge clk);
    bus.in_valid = 1'b0; run_i = 1'b0; rst = 1'b0;
    mon_en = 1'b1;

    // framing of a lone byte: 8 cycles of csi low, then GAP_CYCLES of busy gap
    send(8'hC3, 1'b0, 1'b1);
    n = 0;
    while (!csi && n < 20) begin n++; @(negedge clk); end
    chk("frame_cs_low_cycles", n, 8);
    g = 0;
    while (csi && csd && busy && g < 20) begin g++; @(negedge clk); end
    chk("frame_gap_cycles", g, 2);
    #1 chk("frame_ready_after_gap", bus.in_ready, 1'b1);
    @(negedge clk);

    // randomized bursts, sel switches and run requests
    s = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_i = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        run_i = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) s = ~s;
      d = 8'($urandom);
      send(d, s, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("no_partial_byte", nbits, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
